router_inject_ni: RTL

ROUTER_INJECT_NI -- requirements
Module: router_inject_ni

---
 rtl/router_inject_ni.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/router_inject_ni.sv
// rtl/router_inject_ni.sv - network-interface injection port with per-VC credit tracking
//
// Turns packet requests (dest, len) plus a payload word stream into router
// injection flits. A packet is granted a whole VC up front: it is only accepted
// when one VC already holds enough credits for its head flit plus every payload
// flit, so a packet can never stall mid-flight on credits.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   pkt_valid     in   packet request present
//   pkt_ready     out  request accepted when pkt_valid & pkt_ready
//   pkt_dest      in   destination router address
//   pkt_len       in   payload flit count, 0..MAX_PAYLOAD
//   pay_valid     in   payload word present
//   pay_ready     out  payload word accepted (only in BODY)
//   pay_data      in   payload word
//   channel_out   out  flit: [0] valid, [VC] vc, head, tail, zero, data
//   flow_ctrl_in  in   credit return: [0] valid, upper bits vc
//   error         out  sticky: credit returned to a full counter
module router_inject_ni #(
    parameter int NUM_VCS        = 4,
    parameter int CREDITS_PER_VC = 8,
    parameter int MAX_PAYLOAD    = 4,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pkt_valid,
    output logic                          pkt_ready,
    input  logic [3:0]                    pkt_dest,
    input  logic [2:0]                    pkt_len,
    input  logic                          pay_valid,
    output logic                          pay_ready,
    input  logic [DATA_WIDTH-1:0]         pay_data,
    output logic [DATA_WIDTH+$clog2(NUM_VCS)+3:0] channel_out,
    input  logic [$clog2(NUM_VCS):0]      flow_ctrl_in,
    output logic                          error
);

    localparam int VC_W = $clog2(NUM_VCS);
    localparam int CW   = $clog2(CREDITS_PER_VC + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS_PER_VC);
    localparam logic [2:0]    MAX_LEN  = 3'(MAX_PAYLOAD);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t              r_state, w_state;
    logic [CW-1:0]       r_cred [NUM_VCS];
    logic [VC_W-1:0]     r_rr;
    logic [VC_W-1:0]     r_vc;
    logic [3:0]          r_dest;
    logic [2:0]          r_len;
    logic [2:0]          r_cnt;
    logic                r_err;

    logic [NUM_VCS-1:0]  w_elig;
    logic [NUM_VCS-1:0]  w_inc;
    logic [NUM_VCS-1:0]  w_dec;
    logic                w_any;
    logic [VC_W-1:0]     w_grant;
    logic                w_len_ok;
    logic                w_accept;
    logic                w_fv;
    logic                w_head;
    logic                w_tail;
    logic [DATA_WIDTH-1:0] w_data;
    logic                w_fc_valid;
    logic [VC_W-1:0]     w_fc_vc;
    logic                w_overflow;
    int                  w_idx;

    assign w_fc_valid = flow_ctrl_in[0];
    assign w_fc_vc    = flow_ctrl_in[VC_W:1];
    assign w_len_ok   = (pkt_len <= MAX_LEN);

    // A VC is eligible when it can hold the head flit plus all payload flits.
    always_comb begin
        w_elig = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_elig[v] = ({1'b0, r_cred[v]} >= ((CW+1)'(pkt_len) + (CW+1)'(1)));
        end
    end

    // Round-robin search starting at the VC after the last grant.
    always_comb begin
        w_any   = 1'b0;
        w_grant = r_rr;
        w_idx   = 0;
        for (int i = 1; i <= NUM_VCS; i++) begin
            w_idx = (int'(r_rr) + i) % NUM_VCS;
            if (!w_any && w_elig[w_idx]) begin
                w_any   = 1'b1;
                w_grant = VC_W'(w_idx);
            end
        end
    end

    // Gated by reset so the request side is closed while reset is held.
    assign pkt_ready = reset && (r_state == IDLE) && w_len_ok && w_any;
    assign w_accept  = pkt_valid && pkt_ready;

    always_comb begin
        w_state   = r_state;
        w_fv      = 1'b0;
        w_head    = 1'b0;
        w_tail    = 1'b0;
        w_data    = '0;
        pay_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state = HEAD;
            end
            HEAD: begin
                w_fv        = 1'b1;
                w_head      = 1'b1;
                w_tail      = (r_len == 3'd0);
                w_data[3:0] = r_dest;
                w_data[6:4] = r_len;
                w_state     = (r_len == 3'd0) ? IDLE : BODY;
            end
            BODY: begin
                pay_ready = 1'b1;
                if (pay_valid) begin
                    w_fv   = 1'b1;
                    w_data = pay_data;
                    // r_cnt counts words already sent, so the last word is len-1.
                    w_tail = (r_cnt == (r_len - 3'd1));
                    if (w_tail) w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign channel_out = {w_data, 1'b0, w_tail, w_head, (w_fv ? r_vc : {VC_W{1'b0}}), w_fv};
    assign error       = r_err;

    // Per-VC credit deltas; a simultaneous send and return cancel out.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_inc[v] = w_fc_valid && (w_fc_vc == VC_W'(v));
            w_dec[v] = w_fv && (r_vc == VC_W'(v));
        end
        w_overflow = w_fc_valid && (r_cred[w_fc_vc] == CRED_MAX) && !w_dec[w_fc_vc];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_rr    <= VC_W'(NUM_VCS - 1);
            r_vc    <= '0;
            r_dest  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) r_cred[v] <= CRED_MAX;
        end else begin
            r_state <= w_state;
            if (w_accept) begin
                r_rr   <= w_grant;
                r_vc   <= w_grant;
                r_dest <= pkt_dest;
                r_len  <= pkt_len;
                r_cnt  <= '0;
            end else if ((r_state == BODY) && pay_valid) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_overflow) r_err <= 1'b1;
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_inc[v] && !w_dec[v]) begin
                    if (r_cred[v] != CRED_MAX) r_cred[v] <= r_cred[v] + CW'(1);
                end else if (w_dec[v] && !w_inc[v]) begin
                    r_cred[v] <= r_cred[v] - CW'(1);
                end
            end
        end
    end

endmodule
